// File: rtl/tlram_arb_pkg.sv
// Shared types and constants for the two-port TileLink-UL RAM arbiter.
package tlram_arb_pkg;

  localparam int SRC_W  = 10;
  localparam int ADDR_W = 33;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  localparam logic [2:0] TL_GET             = 3'd4;
  localparam logic [2:0] TL_PUT_FULL        = 3'd0;
  localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
  localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
  localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [1:0]        size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
    logic              corrupt;
  } tl_a_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [1:0]        size;
    logic [SRC_W-1:0]  source;
    logic [DATA_W-1:0] data;
  } tl_d_t;

endpackage

// File: rtl/tlram_arbiter_2_if.sv
// Single-beat TileLink-UL link (A request + D response channels).
// master drives A and accepts D; slave accepts A and drives D.
interface tlram_arbiter_2_if;
  import tlram_arb_pkg::*;

  logic  a_valid;
  logic  a_ready;
  tl_a_t a_bits;
  logic  d_valid;
  logic  d_ready;
  tl_d_t d_bits;

  modport master (output a_valid, a_bits, d_ready, input a_ready, d_valid, d_bits);
  modport slave  (input a_valid, a_bits, d_ready, output a_ready, d_valid, d_bits);
endinterface

// File: rtl/tlram_arb_order_fifo.sv
// Ordering FIFO: remembers which requester issued each outstanding
// request so D responses can be routed back in issue order.
module tlram_arb_order_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic head,
  output logic full,
  output logic empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered count, so a same-cycle pop never frees a slot for a push.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy control; cleared on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage for requester IDs; contents are meaningless while empty so no reset.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/tlram_arbiter_2.sv
// Two-port round-robin TileLink-UL arbiter in front of a single in-order
// RAM slave. A path and D path are combinational; the ordering FIFO steers
// each response to the requester that issued it.
// Optional feature macro: TLRAM_ARB_PERF_EN adds saturating per-port grant counters.
module tlram_arbiter_2
  import tlram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  tlram_arbiter_2_if.slave  in0,
  tlram_arbiter_2_if.slave  in1,
  tlram_arbiter_2_if.master out
`ifdef TLRAM_ARB_PERF_EN
  ,
  output logic [31:0] perf_grant0,
  output logic [31:0] perf_grant1
`endif
);

  logic rr;
  logic grant;
  logic a_open;
  logic a_fire;
  logic d_open;
  logic d_fire;
  logic fifo_full;
  logic fifo_empty;
  logic head;

  // Grant selection: rr breaks ties, a lone valid port always wins.
  always_comb begin
    grant = 1'b0;
    if (in0.a_valid && in1.a_valid) grant = rr;
    else if (in1.a_valid)           grant = 1'b1;
  end

  assign a_open        = ~fifo_full & ~reset;
  assign out.a_valid   = (in0.a_valid | in1.a_valid) & a_open;
  assign out.a_bits    = grant ? in1.a_bits : in0.a_bits;
  assign in0.a_ready   = out.a_ready & a_open & ~grant;
  assign in1.a_ready   = out.a_ready & a_open &  grant;
  assign a_fire        = out.a_valid & out.a_ready;

  // D responses follow the FIFO head; a response with nothing outstanding is never forwarded.
  assign d_open        = ~fifo_empty & ~reset;
  assign in0.d_valid   = out.d_valid & d_open & ~head;
  assign in1.d_valid   = out.d_valid & d_open &  head;
  assign in0.d_bits    = out.d_bits;
  assign in1.d_bits    = out.d_bits;
  assign out.d_ready   = (head ? in1.d_ready : in0.d_ready) & d_open;
  assign d_fire        = out.d_valid & out.d_ready;

  // Round-robin pointer: the port just served loses priority.
  always_ff @(posedge clock) begin
    if (reset)       rr <= 1'b0;
    else if (a_fire) rr <= ~grant;
  end

  tlram_arb_order_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push    (a_fire),
    .push_id (grant),
    .pop     (d_fire),
    .head    (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef TLRAM_ARB_PERF_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Per-port grant counters, saturating at all-ones.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
    end else if (a_fire) begin
      if (grant) perf_grant1 <= sat_inc(perf_grant1);
      else       perf_grant0 <= sat_inc(perf_grant0);
    end
  end
`endif

`ifndef SYNTHESIS
  // A response arriving with no request outstanding means the slave was not reset with us.
  always_ff @(posedge clock) begin
    if (!reset) assert (!(out.d_valid && fifo_empty))
      else $error("tlram_arbiter_2: D response with empty ordering FIFO");
  end
`endif

endmodule

// File: tb/tb_tlram_arbiter_2.sv
// Directed bench for tlram_arbiter_2. Inputs change on the falling edge,
// outputs are sampled 1 time unit later, state commits on the rising edge.
module tb_tlram_arbiter_2;
  import tlram_arb_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  tlram_arbiter_2_if if0();
  tlram_arbiter_2_if if1();
  tlram_arbiter_2_if ifo();

`ifdef TLRAM_ARB_PERF_EN
  logic [31:0] perf_grant0;
  logic [31:0] perf_grant1;
`endif

  tlram_arbiter_2 #(.DEPTH(2)) dut (
    .clock (clock),
    .reset (reset),
    .in0   (if0),
    .in1   (if1),
    .out   (ifo)
`ifdef TLRAM_ARB_PERF_EN
    ,
    .perf_grant0 (perf_grant0),
    .perf_grant1 (perf_grant1)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  // Slave side: either hand-driven D vectors or a one-cycle-latency in-order responder.
  logic             auto_slave;
  logic             slave_vld;
  tl_d_t            slave_bits;
  logic             man_d_valid;
  tl_d_t            man_d_bits;
  logic [SRC_W-1:0] pend[$];

  assign ifo.d_valid = auto_slave ? slave_vld  : man_d_valid;
  assign ifo.d_bits  = auto_slave ? slave_bits : man_d_bits;

  always @(posedge clock) begin
    if (reset || !auto_slave) begin
      pend.delete();
    end else begin
      if (ifo.d_valid && ifo.d_ready && pend.size() > 0) void'(pend.pop_front());
      if (ifo.a_valid && ifo.a_ready) pend.push_back(ifo.a_bits.source);
    end
    slave_vld  <= (pend.size() != 0);
    slave_bits <= '{opcode: TL_ACCESS_ACK_DATA, size: 2'd3,
                    source: (pend.size() != 0) ? pend[0] : '0,
                    data:   (pend.size() != 0) ? {54'd0, pend[0]} : '0};
  end

  task automatic clear_inputs();
    if0.a_valid = 1'b0; if0.a_bits = '0; if0.d_ready = 1'b0;
    if1.a_valid = 1'b0; if1.a_bits = '0; if1.d_ready = 1'b0;
    ifo.a_ready = 1'b0;
    man_d_valid = 1'b0; man_d_bits = '0;
  endtask

  task automatic set_req(input int port, input logic [2:0] op, input logic [SRC_W-1:0] src,
                         input logic [ADDR_W-1:0] addr, input logic [MASK_W-1:0] mask,
                         input logic [DATA_W-1:0] data);
    tl_a_t a;
    a = '{opcode: op, param: 3'd0, size: 2'd2, source: src, address: addr,
          mask: mask, data: data, corrupt: 1'b0};
    if (port == 0) begin if0.a_bits = a; if0.a_valid = 1'b1; end
    else           begin if1.a_bits = a; if1.a_valid = 1'b1; end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    clear_inputs();
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; clear_inputs();
    if0.a_valid = 1'b1; if1.a_valid = 1'b1; ifo.a_ready = 1'b1;
    man_d_valid = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b1;
    #1;
    vectors++; if (if0.a_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in0_a_ready got %b want 0", if0.a_ready); end
    vectors++; if (if1.a_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in1_a_ready got %b want 0", if1.a_ready); end
    vectors++; if (ifo.a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_a_valid got %b want 0", ifo.a_valid); end
    vectors++; if (ifo.d_ready !== 1'b0) begin miscompares++; $display("FAIL rst_out_d_ready got %b want 0", ifo.d_ready); end
    vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b00) begin miscompares++; $display("FAIL rst_in_d_valid got %b want 00", {if0.d_valid, if1.d_valid}); end
    @(negedge clock);
    reset = 1'b0; clear_inputs();
    #1;
    vectors++; if (dut.rr !== 1'b0) begin miscompares++; $display("FAIL rst_rr got %b want 0", dut.rr); end
    vectors++; if (dut.u_fifo.count !== 2'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", dut.u_fifo.count); end
  endtask

  task automatic test_single();
    tl_a_t exp_a;
    auto_slave = 1'b0;
    do_reset();
    set_req(0, TL_PUT_PARTIAL, 10'h005, 33'h0_8000_0008, 8'h0F, 64'h0000_0000_DEAD_BEEF);
    ifo.a_ready = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b1;
    exp_a = '{opcode: 3'd1, param: 3'd0, size: 2'd2, source: 10'h005, address: 33'h0_8000_0008,
              mask: 8'h0F, data: 64'h0000_0000_DEAD_BEEF, corrupt: 1'b0};
    #1;
    vectors++; if (ifo.a_valid !== 1'b1) begin miscompares++; $display("FAIL put_out_a_valid got %b want 1", ifo.a_valid); end
    vectors++; if (ifo.a_bits !== exp_a) begin miscompares++; $display("FAIL put_out_a_bits got %h want %h", ifo.a_bits, exp_a); end
    vectors++; if ({if0.a_ready, if1.a_ready} !== 2'b10) begin miscompares++; $display("FAIL put_a_ready got %b want 10", {if0.a_ready, if1.a_ready}); end
    @(negedge clock);
    if0.a_valid = 1'b0;
    man_d_valid = 1'b1;
    man_d_bits  = '{opcode: TL_ACCESS_ACK, size: 2'd2, source: 10'h005, data: '0};
    #1;
    vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b10) begin miscompares++; $display("FAIL ack_d_valid got %b want 10", {if0.d_valid, if1.d_valid}); end
    vectors++; if (ifo.d_ready !== 1'b1) begin miscompares++; $display("FAIL ack_out_d_ready got %b want 1", ifo.d_ready); end
    vectors++; if (if0.d_bits.opcode !== 3'd0 || if0.d_bits.source !== 10'h005) begin miscompares++; $display("FAIL ack_bits got op %0d src %h want op 0 src 005", if0.d_bits.opcode, if0.d_bits.source); end
    @(negedge clock);
    man_d_valid = 1'b0;
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0008, 8'h0F, '0);
    #1;
    vectors++; if (ifo.a_bits.opcode !== 3'd4 || ifo.a_bits.address !== 33'h0_8000_0008) begin miscompares++; $display("FAIL get_out_a got op %0d addr %h want op 4 addr 080000008", ifo.a_bits.opcode, ifo.a_bits.address); end
    vectors++; if (if0.a_ready !== 1'b1) begin miscompares++; $display("FAIL get_in0_a_ready got %b want 1", if0.a_ready); end
    @(negedge clock);
    if0.a_valid = 1'b0;
    man_d_valid = 1'b1;
    man_d_bits  = '{opcode: TL_ACCESS_ACK_DATA, size: 2'd2, source: 10'h005, data: 64'h0000_0000_DEAD_BEEF};
    #1;
    vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b10) begin miscompares++; $display("FAIL ackd_d_valid got %b want 10", {if0.d_valid, if1.d_valid}); end
    vectors++; if (if0.d_bits.data[31:0] !== 32'hDEAD_BEEF || if0.d_bits.opcode !== 3'd1) begin miscompares++; $display("FAIL ackd_bits got op %0d data %h want op 1 data deadbeef", if0.d_bits.opcode, if0.d_bits.data[31:0]); end
    vectors++; if (if1.d_bits.data !== 64'h0000_0000_DEAD_BEEF) begin miscompares++; $display("FAIL ackd_fanout got %h want deadbeef", if1.d_bits.data); end
    @(negedge clock);
    man_d_valid = 1'b0;
    #1;
    vectors++; if (ifo.d_ready !== 1'b0) begin miscompares++; $display("FAIL single_drained_d_ready got %b want 0", ifo.d_ready); end
  endtask

  task automatic test_contention();
    int   rx0;
    int   rx1;
    logic g;
    auto_slave = 1'b1;
    do_reset();
    rx0 = 0; rx1 = 0;
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0010, 8'hFF, '0);
    set_req(1, TL_GET, 10'h3FF, 33'h0_8000_0020, 8'hFF, '0);
    ifo.a_ready = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) begin if0.a_valid = 1'b0; if1.a_valid = 1'b0; end
      #1;
      if (i < 6) begin
        g = (i % 2) == 1;
        vectors++; if ({if0.a_ready, if1.a_ready} !== {~g, g}) begin miscompares++; $display("FAIL rr_grant cyc %0d got %b want %b", i, {if0.a_ready, if1.a_ready}, {~g, g}); end
        vectors++; if (ifo.a_bits.source !== (g ? 10'h3FF : 10'h005)) begin miscompares++; $display("FAIL rr_out_src cyc %0d got %h want %h", i, ifo.a_bits.source, g ? 10'h3FF : 10'h005); end
      end
      if (i >= 1 && i <= 6) begin
        g = ((i - 1) % 2) == 1;
        vectors++; if ({if0.d_valid, if1.d_valid} !== {~g, g}) begin miscompares++; $display("FAIL rr_d_route cyc %0d got %b want %b", i, {if0.d_valid, if1.d_valid}, {~g, g}); end
        vectors++; if (ifo.d_bits.source !== (g ? 10'h3FF : 10'h005)) begin miscompares++; $display("FAIL rr_d_src cyc %0d got %h want %h", i, ifo.d_bits.source, g ? 10'h3FF : 10'h005); end
      end else begin
        vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b00) begin miscompares++; $display("FAIL rr_d_idle cyc %0d got %b want 00", i, {if0.d_valid, if1.d_valid}); end
      end
      if (if0.d_valid && if0.d_ready) rx0++;
      if (if1.d_valid && if1.d_ready) rx1++;
      @(negedge clock);
    end
    vectors++; if (rx0 != 3 || rx1 != 3) begin miscompares++; $display("FAIL rr_resp_count got %0d/%0d want 3/3", rx0, rx1); end
  endtask

  task automatic test_back_pressure();
    auto_slave = 1'b1;
    do_reset();
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0000, 8'hFF, '0);
    set_req(1, TL_GET, 10'h3FF, 33'h0_8000_0008, 8'hFF, '0);
    ifo.a_ready = 1'b1; if0.d_ready = 1'b0; if1.d_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    vectors++; if ({if0.a_ready, if1.a_ready, ifo.a_valid} !== 3'b000) begin miscompares++; $display("FAIL bp_full got rdy/vld %b want 000", {if0.a_ready, if1.a_ready, ifo.a_valid}); end
    vectors++; if ({if0.d_valid, ifo.d_ready} !== 2'b10) begin miscompares++; $display("FAIL bp_d_blocked got %b want 10", {if0.d_valid, ifo.d_ready}); end
    @(negedge clock);
    if0.d_ready = 1'b1;
    #1;
    vectors++; if (ifo.d_ready !== 1'b1) begin miscompares++; $display("FAIL bp_d_release got %b want 1", ifo.d_ready); end
    vectors++; if ({if0.a_ready, ifo.a_valid} !== 2'b00) begin miscompares++; $display("FAIL bp_pop_no_unblock got %b want 00", {if0.a_ready, ifo.a_valid}); end
    @(negedge clock);
    #1;
    vectors++; if ({if0.a_ready, if1.a_ready, ifo.a_valid} !== 3'b101) begin miscompares++; $display("FAIL bp_regrant got %b want 101", {if0.a_ready, if1.a_ready, ifo.a_valid}); end
    vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b01 || ifo.d_bits.source !== 10'h3FF) begin miscompares++; $display("FAIL bp_next_head got %b src %h want 01 src 3ff", {if0.d_valid, if1.d_valid}, ifo.d_bits.source); end
    @(negedge clock);
    if0.a_valid = 1'b0; if1.a_valid = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_head_blocking();
    auto_slave = 1'b1;
    do_reset();
    set_req(1, TL_GET, 10'h3FF, 33'h0_8000_0040, 8'hFF, '0);
    ifo.a_ready = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b0;
    @(negedge clock);
    if1.a_valid = 1'b0;
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0048, 8'hFF, '0);
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if ({ifo.d_ready, if0.d_valid, if1.d_valid} !== 3'b001) begin miscompares++; $display("FAIL hb_blocked cyc %0d got %b want 001", i, {ifo.d_ready, if0.d_valid, if1.d_valid}); end
      @(negedge clock);
      if0.a_valid = 1'b0;
    end
    if1.d_ready = 1'b1;
    #1;
    vectors++; if (ifo.d_ready !== 1'b1 || ifo.d_bits.source !== 10'h3FF) begin miscompares++; $display("FAIL hb_release got rdy %b src %h want 1 3ff", ifo.d_ready, ifo.d_bits.source); end
    @(negedge clock);
    #1;
    vectors++; if ({if0.d_valid, if1.d_valid} !== 2'b10 || ifo.d_bits.source !== 10'h005) begin miscompares++; $display("FAIL hb_second got %b src %h want 10 005", {if0.d_valid, if1.d_valid}, ifo.d_bits.source); end
    @(negedge clock);
  endtask

  task automatic test_reset_midflight();
    auto_slave = 1'b1;
    do_reset();
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0000, 8'hFF, '0);
    ifo.a_ready = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    vectors++; if (dut.u_fifo.count !== 2'd2) begin miscompares++; $display("FAIL mf_fill got %0d want 2", dut.u_fifo.count); end
    @(negedge clock);
    reset = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b1;
    #1;
    vectors++; if ({if0.a_ready, if1.a_ready, ifo.a_valid, ifo.d_ready, if0.d_valid, if1.d_valid} !== 6'b0)
      begin miscompares++; $display("FAIL mf_during_reset got %b want 000000", {if0.a_ready, if1.a_ready, ifo.a_valid, ifo.d_ready, if0.d_valid, if1.d_valid}); end
    @(negedge clock);
    reset = 1'b0; if0.a_valid = 1'b0;
    set_req(1, TL_GET, 10'h3FF, 33'h0_8000_0100, 8'hFF, '0);
    #1;
    vectors++; if (dut.u_fifo.count !== 2'd0 || dut.rr !== 1'b0) begin miscompares++; $display("FAIL mf_after_reset got count %0d rr %b want 0 0", dut.u_fifo.count, dut.rr); end
    vectors++; if ({if1.a_ready, ifo.a_valid} !== 2'b11 || ifo.a_bits.source !== 10'h3FF) begin miscompares++; $display("FAIL mf_first_grant got %b src %h want 11 3ff", {if1.a_ready, ifo.a_valid}, ifo.a_bits.source); end
    @(negedge clock);
    if1.a_valid = 1'b0;
    repeat (2) @(negedge clock);
  endtask

`ifdef TLRAM_ARB_PERF_EN
  task automatic test_perf();
    auto_slave = 1'b1;
    do_reset();
    ifo.a_ready = 1'b1; if0.d_ready = 1'b1; if1.d_ready = 1'b1;
    set_req(0, TL_GET, 10'h005, 33'h0_8000_0000, 8'hFF, '0);
    repeat (5) @(negedge clock);
    if0.a_valid = 1'b0;
    set_req(1, TL_GET, 10'h3FF, 33'h0_8000_0000, 8'hFF, '0);
    repeat (2) @(negedge clock);
    if1.a_valid = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    vectors++; if (perf_grant0 !== 32'd5 || perf_grant1 !== 32'd2) begin miscompares++; $display("FAIL perf_counts got %0d/%0d want 5/2", perf_grant0, perf_grant1); end
    force dut.perf_grant0 = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.perf_grant0;
    if0.a_valid = 1'b1;
    repeat (2) @(negedge clock);
    if0.a_valid = 1'b0;
    #1;
    vectors++; if (perf_grant0 !== 32'hFFFF_FFFF || perf_grant1 !== 32'd2) begin miscompares++; $display("FAIL perf_saturate got %h/%0d want ffffffff/2", perf_grant0, perf_grant1); end
    repeat (2) @(negedge clock);
  endtask
`endif

  initial begin
    reset = 1'b1;
    auto_slave = 1'b0;
    clear_inputs();
    test_reset();
    test_single();
    test_contention();
    test_back_pressure();
    test_head_blocking();
    test_reset_midflight();
`ifdef TLRAM_ARB_PERF_EN
    test_perf();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
